snn_step_scheduler: RTL and testbench

Timestep sequencer for the two-core SNN. Per timestep it launches the enabled neuron cores and waits for every core's done. It then commits their spike vectors into the output spike memory via enable_calc. It also arbitrates that memory between spike capture and Wishbone host access, so a capture never collides with a host cycle and host writes are blocked while a run is in progress.

---
 rtl/snn_sched_pkg.sv | 17 +
 rtl/snn_step_scheduler_if.sv | 33 +++
 rtl/snn_done_tracker.sv | 44 ++++
 rtl/snn_step_scheduler.sv | 135 +++++++++++++
 tb/tb_snn_step_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_sched_pkg.sv
// Shared types for the SNN timestep scheduler: core count, per-core mask and FSM states.
package snn_sched_pkg;

    localparam int unsigned NUM_CORES = 2;

    typedef logic [NUM_CORES-1:0] core_mask_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_NEXT,
        S_FINISH
    } sched_state_e;

endpackage

// File: rtl/snn_step_scheduler_if.sv
// Core handshake, spike-capture strobe and snooped host bank-select/bus signals.
interface snn_step_scheduler_if;
    import snn_sched_pkg::*;

    core_mask_t core_start_o;
    core_mask_t core_done_i;
    core_mask_t enable_calc_o;
    core_mask_t host_core_sel_i;
    core_mask_t core_en_o;
    logic       wbs_cyc_i;
    logic       wbs_stb_i;

    modport master (
        output core_start_o,
        output enable_calc_o,
        output core_en_o,
        input  core_done_i,
        input  host_core_sel_i,
        input  wbs_cyc_i,
        input  wbs_stb_i
    );

    modport slave (
        input  core_start_o,
        input  enable_calc_o,
        input  core_en_o,
        output core_done_i,
        output host_core_sel_i,
        output wbs_cyc_i,
        output wbs_stb_i
    );

endinterface

// File: rtl/snn_done_tracker.sv
// Sticky per-core done collection plus WAIT-phase timeout counter.
module snn_done_tracker
    import snn_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  core_mask_t mask,
    input  core_mask_t done,
    output logic       all_done_c,
    output logic       timeout_c
);

    localparam int unsigned TO_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    core_mask_t      done_seen;
    core_mask_t      done_seen_nxt;
    logic [TO_W-1:0] to_cnt;

    // A done arriving alongside the last missing bit completes the step this cycle.
    assign done_seen_nxt = done_seen | (done & mask);
    assign all_done_c    = en && (done_seen_nxt == mask);
    assign timeout_c     = (TIMEOUT_CYCLES != 0) && en && (to_cnt == TO_W'(TO_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_seen <= '0;
            to_cnt    <= '0;
        end else if (clr) begin
            done_seen <= '0;
            to_cnt    <= '0;
        end else if (en) begin
            done_seen <= done_seen_nxt;
            if (to_cnt != TO_W'(TO_LAST)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: rtl/snn_step_scheduler.sv
// Timestep sequencer: launches enabled cores, collects done, commits spikes, arbitrates the bank memory.
module snn_step_scheduler
    import snn_sched_pkg::*;
#(
    parameter int unsigned STEP_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [STEP_W-1:0] num_steps_i,
    input  core_mask_t        core_mask_i,
    input  logic              irq_clr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              irq_o,
    output logic              error_o,
    output logic [STEP_W-1:0] step_cnt_o,
    snn_step_scheduler_if.master bus
);

    sched_state_e      state;
    core_mask_t        mask_q;
    core_mask_t        core_start_q;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] step_nxt;
    logic              host_cyc_c;
    logic              all_done_c;
    logic              timeout_c;
    logic              run_state_c;

    assign host_cyc_c  = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign step_nxt    = step_cnt_o + STEP_W'(1);
    assign run_state_c = (state == S_LAUNCH) || (state == S_WAIT) ||
                         (state == S_CAPTURE) || (state == S_NEXT);

    // Capture is decoded against the live host strobe so it can never share a cycle with one.
    assign bus.enable_calc_o = (state == S_CAPTURE && !host_cyc_c && !stop_i) ? mask_q : '0;
    assign bus.core_en_o     = busy_o ? '0 : bus.host_core_sel_i;
    assign bus.core_start_o  = core_start_q;

    snn_done_tracker #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_done_tracker (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .clr        (state == S_LAUNCH),
        .en         (state == S_WAIT),
        .mask       (mask_q),
        .done       (bus.core_done_i),
        .all_done_c (all_done_c),
        .timeout_c  (timeout_c)
    );

    // Sequencer; pulse outputs are set on the transition into the state they belong to.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= S_IDLE;
            mask_q       <= '0;
            steps_q      <= '0;
            core_start_q <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            irq_o        <= 1'b0;
            error_o      <= 1'b0;
            step_cnt_o   <= '0;
        end else begin
            core_start_q <= '0;
            done_o       <= 1'b0;
            if (irq_clr_i) begin
                irq_o <= 1'b0;
            end
            if (stop_i && run_state_c) begin
                state  <= S_FINISH;
                done_o <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            mask_q     <= core_mask_i;
                            steps_q    <= num_steps_i;
                            step_cnt_o <= '0;
                            busy_o     <= 1'b1;
                            if (core_mask_i == '0 || num_steps_i == '0) begin
                                error_o <= 1'b1;
                                state   <= S_FINISH;
                                done_o  <= 1'b1;
                            end else begin
                                error_o      <= 1'b0;
                                state        <= S_LAUNCH;
                                core_start_q <= core_mask_i;
                            end
                        end
                    end
                    S_LAUNCH: state <= S_WAIT;
                    S_WAIT: begin
                        if (all_done_c) begin
                            state <= S_CAPTURE;
                        end else if (timeout_c) begin
                            error_o <= 1'b1;
                            state   <= S_FINISH;
                            done_o  <= 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        if (!host_cyc_c) begin
                            state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        step_cnt_o <= step_nxt;
                        if (step_nxt == steps_q) begin
                            state  <= S_FINISH;
                            done_o <= 1'b1;
                        end else begin
                            state        <= S_LAUNCH;
                            core_start_q <= mask_q;
                        end
                    end
                    S_FINISH: begin
                        irq_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Randomised and directed bench for snn_step_scheduler against a run-level reference model.
module tb_snn_step_scheduler;
    import snn_sched_pkg::*;

    localparam int unsigned STEP_W = 16;
    localparam int unsigned TO     = 16;
    localparam int          HOLD   = 10;

    logic              wb_clk_i    = 1'b0;
    logic              wb_rst_ni   = 1'b0;
    logic              start_i     = 1'b0;
    logic              stop_i      = 1'b0;
    logic              irq_clr_i   = 1'b0;
    logic [STEP_W-1:0] num_steps_i = '0;
    core_mask_t        core_mask_i = '0;
    logic              busy_o, done_o, irq_o, error_o;
    logic [STEP_W-1:0] step_cnt_o;

    snn_step_scheduler_if bus();

    snn_step_scheduler #(.STEP_W(STEP_W), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .num_steps_i (num_steps_i),
        .core_mask_i (core_mask_i),
        .irq_clr_i   (irq_clr_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .irq_o       (irq_o),
        .error_o     (error_o),
        .step_cnt_o  (step_cnt_o),
        .bus         (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Monitor state (written only by the monitor)
    int         cyc_n = 0;
    int         n_start = 0, n_start_ok = 0, n_cap = 0, n_cap_ok = 0, n_done = 0, n_collide = 0;
    int         last_start = -1, prev_start = -1, min_gap = 1000000, cap_cyc = 0, done_cyc = 0;
    core_mask_t exp_mask = '0;

    always @(negedge wb_clk_i) begin
        cyc_n++;
        if (|bus.enable_calc_o && bus.wbs_cyc_i && bus.wbs_stb_i) n_collide++;
        if (|bus.core_start_o) begin
            n_start++;
            if (bus.core_start_o == exp_mask) n_start_ok++;
            if (last_start >= 0 && cyc_n - last_start < min_gap) min_gap = cyc_n - last_start;
            prev_start = last_start;
            last_start = cyc_n;
        end
        if (|bus.enable_calc_o) begin
            n_cap++;
            if (bus.enable_calc_o == exp_mask) n_cap_ok++;
            cap_cyc = cyc_n;
        end
        if (done_o) begin
            n_done++;
            done_cyc = cyc_n;
        end
    end

    // Core model: done pulse lat[k] cycles after its start pulse; optional noise on idle cores
    int  lat[NUM_CORES];
    int  rcnt[NUM_CORES];
    bit  resp_en[NUM_CORES];
    bit  noise_en[NUM_CORES];

    always @(negedge wb_clk_i) begin
        core_mask_t d;
        d = '0;
        for (int k = 0; k < int'(NUM_CORES); k++) begin
            if (rcnt[k] > 0) begin
                rcnt[k]--;
                d[k] = (rcnt[k] == 0);
            end
            if (noise_en[k]) d[k] = 1'($urandom_range(0, 1));
            if (resp_en[k] && bus.core_start_o[k]) rcnt[k] = lat[k];
        end
        bus.core_done_i = d;
    end

    int s_start, s_start_ok, s_cap, s_cap_ok, s_done;
    bit host_rand = 1'b0;

    task automatic snap();
        s_start = n_start; s_start_ok = n_start_ok;
        s_cap = n_cap; s_cap_ok = n_cap_ok; s_done = n_done;
    endtask

    task automatic start_run(input core_mask_t m, input logic [STEP_W-1:0] s);
        snap();
        exp_mask = m;
        @(posedge wb_clk_i); #1;
        core_mask_i = m; num_steps_i = s; start_i = 1'b1;
        @(posedge wb_clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = n_done;
        int i  = 0;
        while (n_done == d0 && i < budget) begin
            @(posedge wb_clk_i); #1;
            i++;
            if (n_done == d0 && host_rand) begin
                bus.wbs_cyc_i       = ($urandom_range(0, 3) == 0);
                bus.wbs_stb_i       = bus.wbs_cyc_i & 1'($urandom_range(0, 1));
                bus.host_core_sel_i = core_mask_t'($urandom);
                start_i             = ($urandom_range(0, 7) == 0);
                core_mask_i         = core_mask_t'($urandom);
                num_steps_i         = STEP_W'($urandom);
            end
        end
        start_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        check({tag, "_end"}, 32'(n_done - d0), 32'd1);
    endtask

    task automatic set_cores(input int l0, input int l1, input bit e0, input bit e1);
        lat[0] = l0; lat[1] = l1; resp_en[0] = e0; resp_en[1] = e1;
        noise_en[0] = 1'b0; noise_en[1] = 1'b0;
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.host_core_sel_i = '0;
        set_cores(5, 5, 1'b1, 1'b1);
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_err", 32'(error_o), 32'd0);
        check("rst_step", 32'(step_cnt_o), 32'd0);
        check("rst_start", 32'(bus.core_start_o), 32'd0);
        check("rst_cap", 32'(bus.enable_calc_o), 32'd0);
        wb_rst_ni = 1'b1;

        // Basic: both cores, 3 steps, done 5 cycles after each start
        start_run(2'b11, 16'd3);
        wait_done("basic", 200);
        check("basic_starts", 32'(n_start - s_start), 32'd3);
        check("basic_start_val", 32'(n_start_ok - s_start_ok), 32'd3);
        check("basic_caps", 32'(n_cap - s_cap), 32'd3);
        check("basic_cap_val", 32'(n_cap_ok - s_cap_ok), 32'd3);
        check("basic_step", 32'(step_cnt_o), 32'd3);
        check("basic_irq", 32'(irq_o), 32'd1);
        check("basic_err", 32'(error_o), 32'd0);
        check("basic_busy", 32'(busy_o), 32'd0);
        check("basic_gap", 32'(last_start - prev_start), 32'(lat[0] + 3));
        irq_clr_i = 1'b1;
        @(posedge wb_clk_i); #1;
        irq_clr_i = 1'b0;
        check("irq_clr", 32'(irq_o), 32'd0);

        // Single core; the other core's done line toggles randomly
        set_cores(4, 2, 1'b1, 1'b1);
        noise_en[1] = 1'b1;
        start_run(2'b01, 16'd2);
        wait_done("mask01", 200);
        noise_en[1] = 1'b0;
        check("mask01_caps", 32'(n_cap - s_cap), 32'd2);
        check("mask01_cap_val", 32'(n_cap_ok - s_cap_ok), 32'd2);
        check("mask01_step", 32'(step_cnt_o), 32'd2);
        check("mask01_err", 32'(error_o), 32'd0);

        // Timeout: core1 never answers
        set_cores(3, 3, 1'b1, 1'b0);
        start_run(2'b11, 16'd2);
        wait_done("tmo", 200);
        check("tmo_err", 32'(error_o), 32'd1);
        check("tmo_caps", 32'(n_cap - s_cap), 32'd0);
        check("tmo_starts", 32'(n_start - s_start), 32'd1);
        check("tmo_step", 32'(step_cnt_o), 32'd0);
        check("tmo_len", 32'(done_cyc - last_start), 32'(1 + TO));

        // Host strobe held across capture entry
        set_cores(3, 3, 1'b1, 1'b1);
        bus.host_core_sel_i = 2'b01;
        start_run(2'b01, 16'd1);
        begin
            int i = 0;
            int d;
            while (i < 50 && !bus.core_done_i[0]) begin
                @(negedge wb_clk_i); #2;
                i++;
            end
            check("host_done_seen", 32'(bus.core_done_i[0]), 32'd1);
            d = cyc_n;
            bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
            check("core_en_run", 32'(bus.core_en_o), 32'd0);
            repeat (HOLD) @(posedge wb_clk_i);
            #1;
            bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
            wait_done("host", 100);
            check("host_cap_delay", 32'(cap_cyc - d), 32'(HOLD));
            check("host_caps", 32'(n_cap - s_cap), 32'd1);
            check("core_en_idle", 32'(bus.core_en_o), 32'd1);
        end

        // Stop during WAIT of step 3
        set_cores(5, 5, 1'b1, 1'b1);
        start_run(2'b11, 16'd5);
        begin
            int i = 0;
            while (i < 200 && (n_start - s_start) < 3) begin
                @(posedge wb_clk_i); #1;
                i++;
            end
            check("stop_reach", 32'(n_start - s_start), 32'd3);
        end
        stop_i = 1'b1;
        @(posedge wb_clk_i); #1;
        stop_i = 1'b0;
        wait_done("stop", 50);
        check("stop_step", 32'(step_cnt_o), 32'd2);
        check("stop_err", 32'(error_o), 32'd0);
        check("stop_caps", 32'(n_cap - s_cap), 32'd2);

        // Illegal starts
        start_run(2'b00, 16'd3);
        wait_done("mask0", 20);
        check("mask0_err", 32'(error_o), 32'd1);
        check("mask0_starts", 32'(n_start - s_start), 32'd0);
        start_run(2'b11, 16'd0);
        wait_done("steps0", 20);
        check("steps0_err", 32'(error_o), 32'd1);
        check("steps0_starts", 32'(n_start - s_start), 32'd0);

        // Asynchronous reset mid-WAIT, then a clean run
        start_run(2'b11, 16'd4);
        @(posedge wb_clk_i); #1;
        wb_rst_ni = 1'b0;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_irq", 32'(irq_o), 32'd0);
        check("arst_err", 32'(error_o), 32'd0);
        check("arst_step", 32'(step_cnt_o), 32'd0);
        check("arst_start", 32'(bus.core_start_o), 32'd0);
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b1;
        repeat (10) @(posedge wb_clk_i);
        start_run(2'b11, 16'd2);
        wait_done("post_rst", 200);
        check("post_rst_step", 32'(step_cnt_o), 32'd2);
        check("post_rst_caps", 32'(n_cap - s_cap), 32'd2);
        check("post_rst_err", 32'(error_o), 32'd0);

        // irq_clr coincident with FINISH: set wins
        set_cores(2, 2, 1'b1, 1'b1);
        start_run(2'b01, 16'd1);
        irq_clr_i = 1'b1;
        begin
            int i = 0;
            while (i < 50 && !done_o) begin
                @(posedge wb_clk_i); #1;
                i++;
            end
            check("irq_fin_seen", 32'(done_o), 32'd1);
        end
        @(posedge wb_clk_i); #1;
        irq_clr_i = 1'b0;
        check("irq_set_wins", 32'(irq_o), 32'd1);

        // Random runs with host traffic and mid-run input churn
        host_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            core_mask_t        m;
            logic [STEP_W-1:0] s;
            m = core_mask_t'($urandom_range(1, 3));
            s = STEP_W'($urandom_range(1, 4));
            set_cores(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), m[0], m[1]);
            noise_en[0] = !m[0]; noise_en[1] = !m[1];
            start_run(m, s);
            wait_done("rnd", 600);
            check("rnd_starts", 32'(n_start_ok - s_start_ok), 32'(s));
            check("rnd_caps", 32'(n_cap_ok - s_cap_ok), 32'(s));
            check("rnd_step", 32'(step_cnt_o), 32'(s));
            check("rnd_err", 32'(error_o), 32'd0);
        end
        host_rand = 1'b0;
        bus.host_core_sel_i = '0;

        check("no_collision", 32'(n_collide), 32'd0);
        check("min_start_gap", 32'(min_gap >= 4), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
